// File: rtl/arkanoid_pkg.sv
// Shared constants and types for the Arkanoid stage-loading path.
// Brick code 0 means an empty cell.
package arkanoid_pkg;

    localparam int ROWS      = 30;
    localparam int COLS      = 10;
    localparam int BW        = 3;
    localparam int STAGE_MAX = 2;

    localparam int ROW_W = COLS * BW;
    localparam int AW    = 5;
    localparam int SW    = 2;
    localparam int CNT_W = 9;
    localparam int RC_W  = 4;

    localparam logic [BW-1:0] BRICK_EMPTY = '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } loader_state_t;

    function automatic logic is_valid_stage(input logic [SW-1:0] stage);
        return stage <= SW'(STAGE_MAX);
    endfunction

endpackage

// File: rtl/stage_loader_if.sv
// Bundle between the game FSM, stage_rom, brick-map RAM and the loader.
// slave is the loader's view; master is the surrounding system's view.
interface stage_loader_if;
    import arkanoid_pkg::*;

    logic               start;
    logic [SW-1:0]      stage;
    logic               abort;
    logic               rom_enable;
    logic [AW-1:0]      rom_addr;
    logic [SW-1:0]      rom_stage;
    logic [ROW_W-1:0]   rom_data;
    logic               map_we;
    logic [AW-1:0]      map_addr;
    logic [ROW_W-1:0]   map_data;
    logic               busy;
    logic               done;
    logic               error;
    logic [CNT_W-1:0]   brick_count;

    modport slave (
        input  start, stage, abort, rom_data,
        output rom_enable, rom_addr, rom_stage,
        output map_we, map_addr, map_data,
        output busy, done, error, brick_count
    );

    modport master (
        output start, stage, abort, rom_data,
        input  rom_enable, rom_addr, rom_stage,
        input  map_we, map_addr, map_data,
        input  busy, done, error, brick_count
    );

endinterface

// File: rtl/row_brick_count.sv
// Combinational count of non-empty BW-bit brick fields across one ROM row.
module row_brick_count
    import arkanoid_pkg::*;
(
    input  logic [ROW_W-1:0] i_row,
    output logic [RC_W-1:0]  o_count
);

    // NOTE: combinational logic uses blocking assignments and gives every
    // output a default first, so the loop accumulates and no latch is inferred.
    always_comb begin
        o_count = '0;
        for (int c = 0; c < COLS; c++) begin
            if (i_row[c*BW +: BW] != BRICK_EMPTY) begin
                o_count = o_count + RC_W'(1);
            end
        end
    end

endmodule

// File: rtl/stage_loader.sv
// Walks stage_rom rows 0..ROWS-1 into the brick map, one row per cycle,
// and totals the non-empty bricks so the game FSM knows the clear condition.
module stage_loader
    import arkanoid_pkg::*;
(
    input  logic           clock,
    input  logic           reset_n,
    stage_loader_if.slave  io_bus
);

    loader_state_t     r_state;
    loader_state_t     w_next_state;

    logic [SW-1:0]     r_stage;
    logic [AW-1:0]     r_rom_addr;
    logic              r_map_we;
    logic [AW-1:0]     r_map_addr;
    logic              r_error;
    logic [CNT_W-1:0]  r_brick_count;

    logic              w_accept;
    logic              w_reject;
    logic              w_abort;
    logic              w_last_row;
    logic              w_rom_enable;
    logic              w_busy;
    logic              w_done;
    logic [RC_W-1:0]   w_row_count;

    assign w_accept   = (r_state == ST_IDLE) && io_bus.start &&  is_valid_stage(io_bus.stage);
    assign w_reject   = (r_state == ST_IDLE) && io_bus.start && !is_valid_stage(io_bus.stage);
    assign w_abort    = io_bus.abort && ((r_state == ST_LOAD) || (r_state == ST_DRAIN));
    assign w_last_row = (r_rom_addr == AW'(ROWS - 1));

    always_comb begin
        w_next_state = r_state;
        w_rom_enable = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next_state = ST_LOAD;
            end
            ST_LOAD: begin
                w_rom_enable = 1'b1;
                w_busy       = 1'b1;
                if (w_abort)         w_next_state = ST_IDLE;
                else if (w_last_row) w_next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_busy       = 1'b1;
                w_next_state = w_abort ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                w_done       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next_state;
    end

    row_brick_count u_row_brick_count (
        .i_row   (io_bus.rom_data),
        .o_count (w_row_count)
    );

    // The map port trails the ROM port by one cycle to absorb the ROM read latency;
    // an abort kills the write that would otherwise land in the following cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stage       <= '0;
            r_rom_addr    <= '0;
            r_map_we      <= 1'b0;
            r_map_addr    <= '0;
            r_error       <= 1'b0;
            r_brick_count <= '0;
        end else begin
            r_error    <= w_reject;
            r_map_we   <= w_rom_enable && !w_abort;
            r_map_addr <= r_rom_addr;

            if (w_accept) begin
                r_stage    <= io_bus.stage;
                r_rom_addr <= '0;
            end else if ((r_state == ST_LOAD) && !w_abort && !w_last_row) begin
                r_rom_addr <= r_rom_addr + AW'(1);
            end

            if (w_accept) begin
                r_brick_count <= '0;
            end else if (r_map_we && !w_abort) begin
                r_brick_count <= r_brick_count + CNT_W'(w_row_count);
            end
        end
    end

    assign io_bus.rom_enable  = w_rom_enable;
    assign io_bus.rom_addr    = r_rom_addr;
    assign io_bus.rom_stage   = r_stage;
    assign io_bus.map_we      = r_map_we;
    assign io_bus.map_addr    = r_map_addr;
    assign io_bus.map_data    = io_bus.rom_data;
    assign io_bus.busy        = w_busy;
    assign io_bus.done        = w_done;
    assign io_bus.error       = r_error;
    assign io_bus.brick_count = r_brick_count;

endmodule

// File: tb/tb_stage_loader.sv
// Directed bench for stage_loader with a small behavioural stage_rom model.
module tb_stage_loader;
    import arkanoid_pkg::*;

    localparam logic [29:0] PAT_A = 30'b111_111_111_111_000_111_111_111_111_111; // 9 bricks
    localparam logic [29:0] PAT_B = 30'b001_010_011_100_101_110_111_001_010_000; // 9 bricks
    localparam logic [29:0] PAT_C = 30'b000_000_000_000_000_000_100_010_001_011; // 4 bricks
    localparam logic [29:0] PAT_D = 30'b001_010_011_100_101_110_111_001_010_100; // 10 bricks

    logic clock;
    logic reset_n;
    int   checks;
    int   failures;

    stage_loader_if bus ();

    stage_loader dut (
        .clock   (clock),
        .reset_n (reset_n),
        .io_bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stage 0: 21 bricks. Stage 1: rows 0..19 nine each plus row 20 four = 184.
    // Stage 2: rows 1..18 ten each = 180, row 0 empty.
    function automatic logic [29:0] rom_row(input logic [1:0] s, input logic [4:0] a);
        logic [29:0] r;
        r = '0;
        case (s)
            2'd0: begin
                if (a == 5'd5) r = {10{3'b001}};
                if (a == 5'd6) r = {10{3'b010}};
                if (a == 5'd7) r = 30'd7;
            end
            2'd1: begin
                if (a < 5'd20)  r = a[0] ? PAT_B : PAT_A;
                if (a == 5'd20) r = PAT_C;
            end
            2'd2: begin
                if (a >= 5'd1 && a <= 5'd18) r = PAT_D;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    initial bus.rom_data = '0;
    always @(posedge clock) begin
        if (bus.rom_enable) bus.rom_data <= rom_row(bus.rom_stage, bus.rom_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issues start in the current (IDLE) cycle and follows the load to cycle 33.
    task automatic run_load(input string tag, input logic [1:0] s, input int exp_count,
                            input logic hold, output logic [29:0] row0, output logic [29:0] row2);
        int writes, enables, proto_err, done_cyc, cnt32;
        logic err_seen;
        writes = 0; enables = 0; proto_err = 0; done_cyc = -1; cnt32 = -1; err_seen = 1'b0;
        row0 = 'x; row2 = 'x;
        bus.start = 1'b1;
        bus.stage = s;
        step();
        bus.start = 1'b0;
        check({tag, "_busy_c1"}, 32'(bus.busy), 32'd1);
        for (int cyc = 1; cyc <= 33; cyc++) begin
            if (bus.map_we) begin
                if (bus.map_addr != 5'(writes))     proto_err++;
                if (cyc != writes + 2)              proto_err++;
                if (bus.map_data !== bus.rom_data)  proto_err++;
                if (bus.map_addr == 5'd0) row0 = bus.map_data;
                if (bus.map_addr == 5'd2) row2 = bus.map_data;
                writes++;
            end
            if (bus.rom_enable) begin
                if (bus.rom_addr != 5'(cyc - 1)) proto_err++;
                if (bus.rom_stage != s)          proto_err++;
                enables++;
            end
            if (bus.error) err_seen = 1'b1;
            if (bus.done) begin
                done_cyc = cyc;
                cnt32 = int'(bus.brick_count);
            end
            if (cyc == 33) begin
                check({tag, "_idle_c33"}, 32'({bus.busy, bus.rom_enable, bus.map_we, bus.done}), 32'd0);
            end else begin
                bus.start = hold && (cyc <= 32);
                bus.stage = hold ? 2'd3 : s;
                step();
            end
        end
        bus.start = 1'b0;
        bus.stage = s;
        check({tag, "_writes"},   32'(writes),    32'd30);
        check({tag, "_enables"},  32'(enables),   32'd30);
        check({tag, "_protocol"}, 32'(proto_err), 32'd0);
        check({tag, "_done_cyc"}, 32'(done_cyc),  32'd32);
        check({tag, "_count"},    32'(cnt32),     32'(exp_count));
        check({tag, "_no_error"}, 32'(err_seen),  32'd0);
    endtask

    initial begin
        logic [29:0] row0, row2;
        int bad;
        checks = 0;
        failures = 0;
        reset_n = 1'b0;
        bus.start = 1'b0;
        bus.stage = 2'd0;
        bus.abort = 1'b0;
        step();
        step();
        check("reset_ctrl", 32'({bus.busy, bus.done, bus.error, bus.rom_enable, bus.map_we}), 32'd0);
        check("reset_addr", 32'({bus.rom_addr, bus.map_addr, bus.rom_stage}), 32'd0);
        check("reset_count", 32'(bus.brick_count), 32'd0);
        reset_n = 1'b1;
        step();

        run_load("stage0", 2'd0, 21, 1'b0, row0, row2);

        // Invalid stage: error pulse only, count untouched.
        bus.start = 1'b1;
        bus.stage = 2'd3;
        step();
        bus.start = 1'b0;
        bus.stage = 2'd0;
        check("bad_stage_error", 32'(bus.error), 32'd1);
        check("bad_stage_quiet", 32'({bus.busy, bus.rom_enable}), 32'd0);
        check("bad_stage_count", 32'(bus.brick_count), 32'd21);
        step();
        check("bad_stage_pulse", 32'({bus.error, bus.busy, bus.rom_enable}), 32'd0);

        run_load("stage1", 2'd1, 184, 1'b1, row0, row2);
        check("stage1_row2", 32'(row2), 32'(PAT_A));

        run_load("stage2", 2'd2, 180, 1'b0, row0, row2);
        check("stage2_row0", 32'(row0), 32'd0);

        // Abort in cycle 10: rows 0..7 counted (72), nothing afterwards.
        bus.start = 1'b1;
        bus.stage = 2'd1;
        step();
        bus.start = 1'b0;
        for (int cyc = 1; cyc < 10; cyc++) step();
        check("abort_pre_busy", 32'(bus.busy), 32'd1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("abort_idle", 32'({bus.busy, bus.rom_enable, bus.map_we, bus.done}), 32'd0);
        check("abort_count", 32'(bus.brick_count), 32'd72);
        bad = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (bus.map_we || bus.done || bus.busy || bus.rom_enable) bad++;
            step();
        end
        check("abort_quiet", 32'(bad), 32'd0);
        check("abort_hold_count", 32'(bus.brick_count), 32'd72);

        // Reset asserted mid-load in cycle 15, checked before the next edge.
        bus.start = 1'b1;
        bus.stage = 2'd2;
        step();
        bus.start = 1'b0;
        for (int cyc = 1; cyc < 15; cyc++) step();
        check("prereset_count", 32'(bus.brick_count), 32'd120);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_ctrl", 32'({bus.busy, bus.done, bus.error, bus.rom_enable, bus.map_we}), 32'd0);
        check("async_reset_addr", 32'({bus.rom_addr, bus.map_addr, bus.rom_stage}), 32'd0);
        check("async_reset_count", 32'(bus.brick_count), 32'd0);
        step();
        reset_n = 1'b1;
        step();

        run_load("post_reset", 2'd2, 180, 1'b0, row0, row2);
        check("post_reset_row0", 32'(row0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stage_loader.md
# stage_loader

Sequences a full stage load out of `stage_rom` into the brick-map RAM. On a start request it latches the stage number and walks ROM rows 0..29 with one row per cycle, absorbing the ROM's one-cycle read latency. It forwards each row to the brick-map write port and counts non-empty bricks, so the game FSM knows the clear condition. It sits between the game-control FSM and the `stage_rom`/brick-map pair.

## Interface
- `ROWS`, 30: number of ROM rows loaded; addresses 0..ROWS-1.
- `COLS`, 10: bricks per row.
- `BW`, 3: bits per brick code; a code of 0 means empty.
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  load request; sampled only in IDLE.
- `stage`  in  2  stage to load; latched when `start` is accepted.
- `abort`  in  1  synchronous cancel; returns to IDLE without `done`.
- `rom_enable`  out  1  drives `stage_rom.enable`.
- `rom_addr`  out  5  drives `stage_rom.addr`.
- `rom_stage`  out  2  drives `stage_rom.stage`; holds the latched stage.
- `rom_data`  in  30  from `stage_rom.data`; valid one cycle after `rom_enable`.
- `map_we`  out  1  brick-map write strobe.
- `map_addr`  out  5  brick-map row address.
- `map_data`  out  30  brick-map row data; a direct copy of `rom_data`.
- `busy`  out  1  high from `start` acceptance until `done` or `abort`.
- `done`  out  1  one-cycle pulse after the last row is written.
- `error`  out  1  one-cycle pulse when `start` arrives with `stage`=2'b11.
- `brick_count`  out  9  count of non-empty bricks loaded, 0..300.

## Operation
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - `start`=1 with `stage`≠3: latch `stage`, clear `brick_count`, set `rom_addr`=0, go to LOAD.
  - `start`=1 with `stage`=3: pulse `error` next cycle, stay in IDLE, leave `brick_count` unchanged.
- LOAD:
  - `rom_enable`=1; `rom_addr` increments each cycle.
  - In the cycle `rom_addr`=ROWS-1, go to DRAIN.
- DRAIN: `rom_enable`=0; the final ROM read returns. Go to DONE.
- DONE: `done`=1 and `busy`=0 for one cycle, then IDLE.
- Write pipeline:
  - `map_we` and `map_addr` are registered copies of `rom_enable` and `rom_addr`.
  - `map_data` = `rom_data` combinationally.
- Counting:
  - On each cycle with `map_we`=1, add the number of non-zero BW-bit fields in `rom_data` (0..10) to `brick_count`.
  - The adder is 9 bits wide and cannot overflow (30×10=300<512).
- `abort` in LOAD or DRAIN:
  - Next cycle: IDLE, `rom_enable`=0, `map_we`=0, `busy`=0, no `done`.
  - `brick_count` holds its partial value; the map contents are then undefined.
- `abort` has priority over a state transition in the same cycle. It has no effect in IDLE or DONE.
- `start` is ignored while `busy`=1 or in DONE.
- `rom_addr` never exceeds ROWS-1, so the ROM default (x) rows are never read.

## Timing
- Reset values: `rom_enable`=0, `rom_addr`=0, `rom_stage`=0, `map_we`=0, `map_addr`=0, `busy`=0, `done`=0, `error`=0, `brick_count`=0, state=IDLE.
- Latency, with E0 as the edge that accepts `start`:
  - `busy` and `rom_enable` rise after E0, with `rom_addr`=0 in cycle 1.
  - `rom_addr`=k in cycle k+1.
  - `map_we` is high in cycles 2..31, with `map_addr`=k in cycle k+2.
  - `done` pulses in cycle 32, and `brick_count` is final there.
- A new `start` can be accepted at the earliest in cycle 33 (IDLE).
- Reset mid-load: immediate return to reset values. The map is not rewritten.

## Structure
- Shared package `arkanoid_pkg` holds:
  - constants ROWS=30, COLS=10, BW=3, STAGE_MAX=2;
  - brick code 0 = empty;
  - the state enum `loader_state_t`.
- One sub-module, `row_brick_count`: combinational count of non-zero BW-bit fields across a 30-bit row, output 4 bits.

## Test plan
- Stage 0 load: `start`, `stage`=0. Expect 30 writes with `map_addr` 0..29, `done` in cycle 32, `brick_count`=21.
- Stage 1 load: expect `brick_count`=184, and row 2 written as 30'b111_111_111_111_000_111_111_111_111_111.
- Stage 2 load: expect `brick_count`=180, and row 0 written with a zero contribution to the count.
- Invalid stage: `stage`=3 with `start`. Expect an `error` pulse, `busy` stays 0, no `rom_enable`, `brick_count` unchanged.
- Abort in cycle 10: expect IDLE next cycle, no `done`, no further `map_we`, `brick_count` equal to the sum over rows 0..7.
- Protocol edges:
  - `start` held during busy: ignored.
  - `reset_n` low in cycle 15: all outputs go to reset values asynchronously.
  - After reset, a fresh `start` runs a full 30-row load.
